// File: rtl/clic_irq_tx.sv
// -----------------------------------------------------------------------------
// clic_irq_tx
//   Interrupt-controller side of the CLIC interrupt interface. It holds the
//   per-source configuration and tracks pending state. A registered max-level
//   arbiter picks the winning source. A valid/ready handshake with a kill/ack
//   withdrawal path presents that winner to the core.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   intr_src_i           raw interrupt lines (synchronous to clk_i)
//   cfg_req_i/cfg_we_i   config access strobe / write enable
//   cfg_addr_i           source index of the config access
//   cfg_wdata_i          [15:8] level [7:6] priv [5] shv [4] edge [3] ie
//                        [2] ip_set [1] ip_clr [0] reserved
//   cfg_rdata_o          registered read data, same layout, [2]=ip, [1:0]=0
//   mintthresh_i         core interrupt level threshold
//   irq_valid_o/ready_i  request handshake
//   irq_id_o/level_o/priv_o/shv_o   winning request attributes
//   irq_kill_req_o/irq_kill_ack_i   request withdrawal handshake
// -----------------------------------------------------------------------------
module clic_irq_tx #(
    parameter int NumSrc = 256,
    parameter int SrcW   = $clog2(NumSrc),
    parameter int LvlW   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumSrc-1:0] intr_src_i,
    input  logic              cfg_req_i,
    input  logic              cfg_we_i,
    input  logic [SrcW-1:0]   cfg_addr_i,
    input  logic [15:0]       cfg_wdata_i,
    output logic [15:0]       cfg_rdata_o,
    input  logic [LvlW-1:0]   mintthresh_i,
    output logic              irq_valid_o,
    input  logic              irq_ready_i,
    output logic [SrcW-1:0]   irq_id_o,
    output logic [LvlW-1:0]   irq_level_o,
    output logic [1:0]        irq_priv_o,
    output logic              irq_shv_o,
    output logic              irq_kill_req_o,
    input  logic              irq_kill_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_KILL   = 2'd2
    } state_e;

    // Per-source configuration and pending state
    logic [LvlW-1:0]   level_r [NumSrc];
    logic [1:0]        priv_r  [NumSrc];
    logic [NumSrc-1:0] shv_r;
    logic [NumSrc-1:0] edge_r;
    logic [NumSrc-1:0] ie_r;
    logic [NumSrc-1:0] ip_r;
    logic [NumSrc-1:0] prev_r;

    logic              cfg_wr_s;
    logic              rsvd_unused_s;
    logic [NumSrc-1:0] set_s;
    logic [NumSrc-1:0] clr_s;
    logic [NumSrc-1:0] ip_eff_s;
    logic [NumSrc-1:0] cand_s;

    // Arbiter combinational result and its registered copy
    logic              arb_found_s;
    logic [SrcW-1:0]   arb_id_s;
    logic [LvlW-1:0]   arb_lvl_s;
    logic              win_found_r;
    logic [SrcW-1:0]   win_id_r;
    logic [LvlW-1:0]   win_lvl_r;
    logic [1:0]        win_priv_r;
    logic              win_shv_r;

    // Handshake FSM and registered outputs
    state_e            state_r;
    state_e            next_state_s;
    logic              claim_s;
    logic              load_s;
    logic              valid_r;
    logic              kill_r;
    logic [SrcW-1:0]   id_r;
    logic [LvlW-1:0]   lvl_r;
    logic [1:0]        priv_out_r;
    logic              shv_out_r;
    logic [15:0]       rdata_r;

    assign cfg_wr_s      = cfg_req_i & cfg_we_i;
    assign rsvd_unused_s = cfg_wdata_i[0];

    // Configuration registers: a write lands on the next clock edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumSrc; i++) begin
                level_r[i] <= '0;
                priv_r[i]  <= 2'b00;
            end
            shv_r  <= '0;
            edge_r <= '0;
            ie_r   <= '0;
        end else if (cfg_wr_s) begin
            level_r[cfg_addr_i] <= LvlW'(cfg_wdata_i[15:8]);
            priv_r[cfg_addr_i]  <= cfg_wdata_i[7:6];
            shv_r[cfg_addr_i]   <= cfg_wdata_i[5];
            edge_r[cfg_addr_i]  <= cfg_wdata_i[4];
            ie_r[cfg_addr_i]    <= cfg_wdata_i[3];
        end
    end

    // Set/clear requests for edge-triggered pending bits
    always_comb begin
        set_s = '0;
        clr_s = '0;
        for (int i = 0; i < NumSrc; i++) begin
            set_s[i] = (intr_src_i[i] & ~prev_r[i]) |
                       (cfg_wr_s & (cfg_addr_i == SrcW'(i)) & cfg_wdata_i[2]);
            clr_s[i] = (claim_s & (irq_id_o == SrcW'(i))) |
                       (cfg_wr_s & (cfg_addr_i == SrcW'(i)) & cfg_wdata_i[1]);
        end
    end

    // Edge history and pending bits; set has priority over clear, and
    // level-triggered sources keep the stored bit at 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_r <= '0;
            ip_r   <= '0;
        end else begin
            prev_r <= intr_src_i;
            ip_r   <= edge_r & (set_s | (ip_r & ~clr_s));
        end
    end

    // Effective pending view: stored bit for edge sources, live line otherwise
    always_comb begin
        ip_eff_s = (edge_r & ip_r) | (~edge_r & intr_src_i);
    end

    // Candidate mask. An edge source being claimed this cycle is excluded
    // already, so the registered winner never shows a just-claimed id during
    // the IDLE cycle that follows the claim.
    always_comb begin
        cand_s = '0;
        for (int i = 0; i < NumSrc; i++) begin
            cand_s[i] = ip_eff_s[i] & ie_r[i] & (level_r[i] > mintthresh_i) &
                        ~(claim_s & edge_r[i] & ~set_s[i] & (irq_id_o == SrcW'(i)));
        end
    end

    // Max-level search; ">=" while scanning upward makes the higher id win ties
    always_comb begin
        arb_found_s = 1'b0;
        arb_id_s    = '0;
        arb_lvl_s   = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (cand_s[i] && (!arb_found_s || (level_r[i] >= arb_lvl_s))) begin
                arb_found_s = 1'b1;
                arb_id_s    = SrcW'(i);
                arb_lvl_s   = level_r[i];
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Registered arbitration result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_found_r <= 1'b0;
            win_id_r    <= '0;
            win_lvl_r   <= '0;
            win_priv_r  <= 2'b00;
            win_shv_r   <= 1'b0;
        end else begin
            win_found_r <= arb_found_s;
            win_id_r    <= arb_id_s;
            win_lvl_r   <= arb_lvl_s;
            win_priv_r  <= priv_r[arb_id_s];
            win_shv_r   <= shv_r[arb_id_s];
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a claim takes priority over a kill condition
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_r) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (irq_ready_i) begin
                    next_state_s = ST_IDLE;
                end else if (!win_found_r || (win_id_r != id_r)) begin
                    next_state_s = ST_KILL;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_KILL: begin
                if (irq_kill_ack_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_KILL;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: claim pulse and winner capture strobe
    always_comb begin
        claim_s = 1'b0;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = win_found_r;
            end
            ST_ACCESS: begin
                claim_s = irq_ready_i;
            end
            ST_KILL: begin
                claim_s = 1'b0;
            end
            default: begin
                claim_s = 1'b0;
                load_s  = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs; attributes stay frozen outside IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_r    <= 1'b0;
            kill_r     <= 1'b0;
            id_r       <= '0;
            lvl_r      <= '0;
            priv_out_r <= 2'b00;
            shv_out_r  <= 1'b0;
        end else begin
            valid_r <= (next_state_s == ST_ACCESS);
            kill_r  <= (next_state_s == ST_KILL);
            if (load_s) begin
                id_r       <= win_id_r;
                lvl_r      <= win_lvl_r;
                priv_out_r <= win_priv_r;
                shv_out_r  <= win_shv_r;
            end
        end
    end

    // Registered config read data, held between reads
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_r <= 16'h0000;
        end else if (cfg_req_i && !cfg_we_i) begin
            rdata_r <= {8'(level_r[cfg_addr_i]), priv_r[cfg_addr_i],
                        shv_r[cfg_addr_i], edge_r[cfg_addr_i], ie_r[cfg_addr_i],
                        ip_eff_s[cfg_addr_i], 2'b00};
        end
    end

    assign cfg_rdata_o    = rdata_r;
    assign irq_valid_o    = valid_r;
    assign irq_kill_req_o = kill_r;
    assign irq_id_o       = id_r;
    assign irq_level_o    = lvl_r;
    assign irq_priv_o     = priv_out_r;
    assign irq_shv_o      = shv_out_r;

endmodule

// File: doc/clic_irq_tx.md
Name: clic_irq_tx

Overview:
- Interrupt-controller end of the CVA6 SCLIC interrupt interface; the core's CLIC port (RVSCLIC=1, CLICNumInterruptSrc=256) is the receiver.
- Per source, the block holds configuration (enable, trigger, level, privilege, vectoring) and tracks pending state.
- A pipelined max-level arbiter selects the winning source.
- A valid/ready + kill handshake presents the winner to the core.

Parameters:
NumSrc, 256, number of interrupt sources (power of two, >=2)
SrcW, $clog2(NumSrc), source-id width
LvlW, 8, interrupt level width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
intr_src_i  in  NumSrc  raw interrupt lines, synchronous to clk_i
cfg_req_i  in  1  config access strobe
cfg_we_i  in  1  1=write, 0=read
cfg_addr_i  in  SrcW  source index
cfg_wdata_i  in  16  [15:8] level, [7:6] priv, [5] shv, [4] edge, [3] ie, [2] ip_set, [1] ip_clr, [0] rsvd
cfg_rdata_o  out  16  same layout; [2] reads ip, [1:0] read 0
mintthresh_i  in  LvlW  core interrupt threshold
irq_valid_o  out  1  interrupt request to core
irq_ready_i  in  1  core accepts request
irq_id_o  out  SrcW  winning source id
irq_level_o  out  LvlW  winning level
irq_priv_o  out  2  winning privilege
irq_shv_o  out  1  selective hardware vectoring
irq_kill_req_o  out  1  withdraw outstanding request
irq_kill_ack_i  in  1  core acknowledges withdrawal

Behaviour:
- Reset: all per-source config is 0, all ip=0, edge-detect history=0, FSM=IDLE. All outputs are 0, including cfg_rdata_o.
- Pending, level-triggered (edge=0): ip = intr_src_i[i]. ip_set and ip_clr are ignored.
- Pending, edge-triggered (edge=1): ip sets on a 0->1 transition of intr_src_i[i], sampled against the registered previous value.
  - ip clears on claim of that id, or on a cfg write with ip_clr=1.
  - ip sets on a cfg write with ip_set=1.
  - If a set and a clear occur in the same cycle, set wins.
- Config write: takes effect on the next clock edge.
- Config read: cfg_rdata_o is registered, valid the cycle after cfg_req_i. It holds its value otherwise.
- Candidate: ip & ie & (level > mintthresh_i).
- Arbitration:
  - Highest level wins; on equal level, the higher id wins.
  - The result (found, id, level, priv, shv) is registered, so there is 1 cycle from a source-state change to a candidate update.
- FSM IDLE:
  - Enters ACCESS when found=1.
  - Latches id/level/priv/shv into the output registers.
  - Asserts irq_valid_o in the next cycle.
- FSM ACCESS:
  - Outputs are held stable while irq_valid_o=1.
  - irq_ready_i=1 -> claim. Pulse clears ip of irq_id_o if that source is edge-triggered. Deassert valid next cycle, go to IDLE.
  - Else if the registered winner has a changed id, or found=0 -> go to KILL. Valid drops and irq_kill_req_o=1 from the next cycle.
  - If ready and a kill condition occur in the same cycle, ready wins (claim).
- FSM KILL:
  - irq_kill_req_o is held until irq_kill_ack_i=1, then goes to IDLE with kill_req deasserted next cycle. No claim occurs.
  - irq_ready_i is ignored in KILL.
- IDLE is held for at least 1 cycle after a claim or kill, so valid is never asserted back-to-back without a low cycle.
- Async reset mid-handshake: immediately returns to IDLE with all outputs 0. Edge ip is lost.
- Width rules: level comparison is unsigned LvlW. cfg_addr_i >= NumSrc cannot occur (power-of-two NumSrc).

Test Plan:
1. Level-triggered src 5: cfg write ie=1, level=0x40; thresh=0x10; raise intr_src_i[5] -> irq_valid_o within 3 cycles with id=5, level=0x40. Ready asserted -> valid low next cycle; it reasserts after 1 IDLE cycle while the line stays high.
2. Edge-triggered src 7, level 0x20: 1-cycle pulse -> request id=7. On claim, ip[7] reads 0 via cfg read. A second pulse is reissued.
3. Tie-break: srcs 3 and 200, both level 0x80 edge-pending, simultaneously -> id=200 first. After claim, id=3.
4. Preemption: src 10 level 0x30 valid, ready held low; src 11 level 0x90 fires -> valid drops, kill_req=1. Ack after 4 cycles -> IDLE, then request id=11, level=0x90. ip[10] stays 1.
5. Threshold: level 0x10 pending with thresh=0x10 -> no valid. Lowering thresh to 0x0F -> valid.
6. Reset with valid=1 mid-ACCESS -> all outputs 0 the same cycle. After release, a level source still high is re-requested. An edge source is not re-requested.
